// File: rtl/vga_timing_pkg.sv
// Shared raster timing for the 640x480@60 VGA path.
// Holds the default porch/sync constants and the sync bundle consumed by renderers.
package vga_timing_pkg;

    localparam int POS_W = 10;

    localparam int VGA_H_DISPLAY = 640;
    localparam int VGA_H_FRONT   = 16;
    localparam int VGA_H_SYNC    = 96;
    localparam int VGA_H_BACK    = 48;
    localparam int VGA_V_DISPLAY = 480;
    localparam int VGA_V_FRONT   = 10;
    localparam int VGA_V_SYNC    = 2;
    localparam int VGA_V_BACK    = 33;

    localparam int VGA_H_TOTAL = VGA_H_DISPLAY + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
    localparam int VGA_V_TOTAL = VGA_V_DISPLAY + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

    // Sync windows are half-open: [START, END)
    localparam int VGA_H_SYNC_START = VGA_H_DISPLAY + VGA_H_FRONT;
    localparam int VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC;
    localparam int VGA_V_SYNC_START = VGA_V_DISPLAY + VGA_V_FRONT;
    localparam int VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC;

    typedef struct packed {
        logic [POS_W-1:0] hpos;
        logic [POS_W-1:0] vpos;
        logic             hsync;
        logic             vsync;
        logic             display_on;
    } vga_sync_t;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with registered sync and active flags.
// sync/active are computed from the next position so they line up with pos.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int DISPLAY = VGA_H_DISPLAY,
    parameter int FRONT   = VGA_H_FRONT,
    parameter int SYNC    = VGA_H_SYNC,
    parameter int BACK    = VGA_H_BACK,
    parameter bit POL     = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             step,
    output logic [POS_W-1:0] pos,
    output logic             sync,
    output logic             active,
    output logic             wrap
);

    localparam int TOTAL    = DISPLAY + FRONT + SYNC + BACK;
    localparam int SYNC_LO  = DISPLAY + FRONT;
    localparam int SYNC_HI  = DISPLAY + FRONT + SYNC;
    localparam logic [POS_W-1:0] LAST   = TOTAL[POS_W-1:0] - 1'b1;
    localparam logic [POS_W:0]   DISP_L = DISPLAY[POS_W:0];
    localparam logic [POS_W:0]   SYNC_L = SYNC_LO[POS_W:0];
    localparam logic [POS_W:0]   SYNC_H = SYNC_HI[POS_W:0];

    logic [POS_W-1:0] pos_reg, pos_next;
    logic             sync_reg, active_reg;
    logic             in_sync_next;

    assign wrap = (pos_reg == LAST);

    always_comb begin
        pos_next = pos_reg;
        if (step) begin
            pos_next = wrap ? '0 : pos_reg + 1'b1;
        end
        in_sync_next = ({1'b0, pos_next} >= SYNC_L) && ({1'b0, pos_next} < SYNC_H);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_reg    <= LAST;
            sync_reg   <= ~POL;
            active_reg <= 1'b0;
        end else begin
            pos_reg    <= pos_next;
            sync_reg   <= in_sync_next ? POL : ~POL;
            active_reg <= ({1'b0, pos_next} < DISP_L);
        end
    end

    assign pos    = pos_reg;
    assign sync   = sync_reg;
    assign active = active_reg;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: pixel position, syncs, display enable, line/frame strobes.
// All outputs are registered from next-position logic so they describe the same pixel.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int H_DISPLAY = VGA_H_DISPLAY,
    parameter int H_FRONT   = VGA_H_FRONT,
    parameter int H_SYNC    = VGA_H_SYNC,
    parameter int H_BACK    = VGA_H_BACK,
    parameter int V_DISPLAY = VGA_V_DISPLAY,
    parameter int V_FRONT   = VGA_V_FRONT,
    parameter int V_SYNC    = VGA_V_SYNC,
    parameter int V_BACK    = VGA_V_BACK,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int FRAME_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    output logic [POS_W-1:0]   hpos,
    output logic [POS_W-1:0]   vpos,
    output logic               hsync,
    output logic               vsync,
    output logic               display_on,
    output logic               line_start,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame_cnt
);

    localparam logic [POS_W:0] H_LIM = H_DISPLAY[POS_W:0];
    localparam logic [POS_W:0] V_LIM = V_DISPLAY[POS_W:0];

    logic               h_wrap, v_wrap, h_active, v_active, v_step;
    logic [POS_W-1:0]   hpos_next, vpos_next;
    logic               display_on_reg, display_on_next;
    logic               line_start_reg, frame_start_reg, at_origin;
    logic [FRAME_W-1:0] frame_cnt_reg;

    assign v_step = ena & h_wrap;

    vga_axis_counter #(
        .DISPLAY(H_DISPLAY), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK), .POL(HSYNC_POL)
    ) u_h_axis (
        .clk(clk), .rst_n(rst_n), .step(ena),
        .pos(hpos), .sync(hsync), .active(h_active), .wrap(h_wrap)
    );

    vga_axis_counter #(
        .DISPLAY(V_DISPLAY), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK), .POL(VSYNC_POL)
    ) u_v_axis (
        .clk(clk), .rst_n(rst_n), .step(v_step),
        .pos(vpos), .sync(vsync), .active(v_active), .wrap(v_wrap)
    );

    // While frozen the axis flags already describe the held pixel.
    always_comb begin
        hpos_next = hpos;
        vpos_next = vpos;
        if (ena) begin
            hpos_next = h_wrap ? '0 : hpos + 1'b1;
        end
        if (v_step) begin
            vpos_next = v_wrap ? '0 : vpos + 1'b1;
        end
        at_origin       = v_step & v_wrap;
        display_on_next = h_active & v_active;
        if (ena) begin
            display_on_next = ({1'b0, hpos_next} < H_LIM) && ({1'b0, vpos_next} < V_LIM);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            display_on_reg  <= 1'b0;
            line_start_reg  <= 1'b0;
            frame_start_reg <= 1'b0;
            frame_cnt_reg   <= '0;
        end else begin
            display_on_reg  <= display_on_next;
            line_start_reg  <= v_step;
            frame_start_reg <= at_origin;
            if (at_origin) begin
                frame_cnt_reg <= frame_cnt_reg + 1'b1;
            end
        end
    end

    assign display_on  = display_on_reg;
    assign line_start  = line_start_reg;
    assign frame_start = frame_start_reg;
    assign frame_cnt   = frame_cnt_reg;

endmodule
